// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI AR/R channel pair between NREQ read clients.
// Optional AR stall counter enabled by defining AXI_RD_ARB_STATS_EN.
module axi_rd_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [64*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]    req_len,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [511:0]         rsp_data,
  output logic                 rsp_last,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [15:0]          arid_m,
  output logic [63:0]          araddr_m,
  output logic [7:0]           arlen_m,
  output logic [2:0]           arsize_m,
  output logic                 arvalid_m,
  input  logic                 arready_m,
  input  logic [15:0]          rid_m,
  input  logic [511:0]         rdata_m,
  input  logic [1:0]           rresp_m,
  input  logic                 rlast_m,
  input  logic                 rvalid_m,
  output logic                 rready_m,
  output logic                 err,
  output logic [31:0]          stall_cnt
);
  typedef enum logic {IDLE, ISSUE} state_t;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
  state_t state, state_nx;
  logic [NREQ-1:0] busy, clr_mask, set_mask;
  logic [IDXW-1:0] ptr, idx, gnt_idx, k;
  logic gnt_any, bad, xfer, hs;
  int c;
  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    c = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      c = (int'(ptr) + j) % NREQ;
      if (req_valid[c] && !busy[c]) begin
        gnt_any = 1'b1;
        gnt_idx = IDXW'(c);
      end
    end
  end
  always_comb begin
    state_nx  = (state == IDLE) ? (gnt_any ? ISSUE : IDLE) : (arready_m ? IDLE : ISSUE);
    req_ready = (rst && state == IDLE && gnt_any) ? ONE << gnt_idx : '0;
    hs        = state == ISSUE && arready_m;
    k         = rid_m[IDXW-1:0];
    bad       = (|rid_m[15:IDXW]) || int'(k) >= NREQ;
    rsp_valid = (bad || !rvalid_m) ? '0 : ONE << k;
    rready_m  = bad | rsp_ready[k];
    xfer      = rvalid_m & rready_m;
    clr_mask  = (xfer && rlast_m && !bad) ? ONE << k : '0;
    set_mask  = hs ? ONE << idx : '0;
  end
  assign rsp_data  = rdata_m;
  assign rsp_last  = rlast_m;
  assign arvalid_m = state == ISSUE;
  assign arid_m    = {{(16 - IDXW){1'b0}}, idx};
  assign arsize_m  = 3'd6;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= '0;
      ptr      <= '0;
      idx      <= '0;
      araddr_m <= '0;
      arlen_m  <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (busy & ~clr_mask) | set_mask;
      if (state == IDLE && gnt_any) begin
        idx      <= gnt_idx;
        araddr_m <= req_addr[64*gnt_idx +: 64];
        arlen_m  <= req_len[8*gnt_idx +: 8];
      end
      if (hs) ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + IDXW'(1);
      // Beats for a requester with nothing outstanding are unexpected.
      if (xfer && (bad || rresp_m != 2'b00 || !busy[k])) err <= 1'b1;
    end
  end
`ifdef AXI_RD_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (arvalid_m && !arready_m && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench for axi_rd_arbiter; AR grants checked against a queue of expected bursts.
module tb_axi_rd_arbiter;
  localparam int NREQ = 4;
  localparam int IDXW = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [64*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_len;
  logic [511:0] rsp_data, rdata_m = '0;
  logic rsp_last, arvalid_m, arready_m = 1'b0, rlast_m = 1'b0, rvalid_m = 1'b0, rready_m, err;
  logic [15:0] arid_m, rid_m = '0;
  logic [63:0] araddr_m;
  logic [7:0] arlen_m;
  logic [2:0] arsize_m;
  logic [1:0] rresp_m = '0;
  logic [31:0] stall_cnt;
  typedef struct {logic [15:0] id; logic [63:0] addr; logic [7:0] len;} ar_t;
  ar_t ar_q[$];
  int n_chk = 0, n_fail = 0;

  axi_rd_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_ready(rsp_ready), .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m),
    .arsize_m(arsize_m), .arvalid_m(arvalid_m), .arready_m(arready_m), .rid_m(rid_m),
    .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m), .rvalid_m(rvalid_m),
    .rready_m(rready_m), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (rst && arvalid_m && arready_m) begin
      if (ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
      else begin
        ar_t e;
        e = ar_q.pop_front();
        check("arid", 64'(arid_m), 64'(e.id));
        check("araddr", araddr_m, e.addr);
        check("arlen", 64'(arlen_m), 64'(e.len));
        check("arsize", 64'(arsize_m), 64'd6);
      end
    end
  end

  task automatic do_reset;
    rst = 1'b0;
    req_valid = '0;
    rvalid_m = 1'b0;
    ar_q.delete();
    step;
    step;
    rst = 1'b1;
    step;
  endtask

  task automatic expect_grant(input int e);
    int t;
    ar_t a;
    t = 0;
    a.id = 16'(e);
    a.addr = req_addr[64*e +: 64];
    a.len = req_len[8*e +: 8];
    ar_q.push_back(a);
    while (req_ready == '0 && t < 20) begin
      step;
      t++;
    end
    check("grant", 64'(req_ready), 64'(1) << e);
  endtask

  task automatic beat(input int id, input bit last, input logic [1:0] resp);
    logic [511:0] d;
    d = {16{$urandom}};
    rid_m = 16'(id);
    rdata_m = d;
    rlast_m = last;
    rresp_m = resp;
    rvalid_m = 1'b1;
    #1;
    check("rsp_valid", 64'(rsp_valid), id < NREQ ? 64'(1) << id : 64'd0);
    check("rready", 64'(rready_m), id < NREQ ? 64'(rsp_ready[id]) : 64'd1);
    check("rsp_data", rsp_data[511:448], d[511:448]);
    check("rsp_last", 64'(rsp_last), 64'(last));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[64*i +: 64] = 64'h1000 * (i + 1);
      req_len[8*i +: 8] = 8'(i);
    end
    req_valid = '1;
    #1;
    check("rst_arvalid", 64'(arvalid_m), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_araddr", araddr_m, 64'd0);
    check("rst_arid", 64'(arid_m), 64'd0);
    do_reset;
    // single request
    req_addr[63:0] = 64'h40;
    req_len[7:0] = 8'd0;
    arready_m = 1'b1;
    req_valid = 4'b0001;
    #1;
    expect_grant(0);
    step;
    req_valid = '0;
    check("t1_arvalid", 64'(arvalid_m), 64'd1);
    check("t1_araddr", araddr_m, 64'h40);
    check("t1_arid", 64'(arid_m), 64'd0);
    step;
    beat(0, 1'b1, 2'b00);
    step;
    rvalid_m = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("t1_busy_clr", 64'(req_ready), 64'd1);
    expect_grant(0);
    step;
    req_valid = '0;
    step;
    beat(0, 1'b1, 2'b00);
    step;
    rvalid_m = 1'b0;
    // contention: order 0,1,2,3,0
    do_reset;
    req_addr[63:0] = 64'h1000;
    req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      expect_grant(g % NREQ);
      if (g > 0) begin
        step;
        rvalid_m = 1'b0;
      end else step;
      check("rr_arvalid", 64'(arvalid_m), 64'd1);
      check("rr_pulse", 64'(req_ready), 64'd0);
      step;
      beat(g % NREQ, 1'b1, 2'b00);
      if (g == 4) req_valid = '0;
      #1;
    end
    step;
    rvalid_m = 1'b0;
    // AR backpressure
    do_reset;
    arready_m = 1'b0;
    req_valid = 4'b0010;
    #1;
    expect_grant(1);
    step;
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      check("bp_arvalid", 64'(arvalid_m), 64'd1);
      check("bp_araddr", araddr_m, 64'h2000);
      check("bp_arlen", 64'(arlen_m), 64'd1);
      step;
    end
`ifdef AXI_RD_ARB_STATS_EN
    check("stall_cnt", 64'(stall_cnt), 64'd5);
`else
    check("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    arready_m = 1'b1;
    step;
    // R steering with requester backpressure
    rsp_ready = 4'b1101;
    beat(1, 1'b1, 2'b00);
    step;
    check("held_valid", 64'(rsp_valid), 64'd2);
    check("held_rready", 64'(rready_m), 64'd0);
    rsp_ready = '1;
    #1;
    check("rel_rready", 64'(rready_m), 64'd1);
    step;
    rvalid_m = 1'b0;
    // busy requester blocked until its last beat
    req_len[23:16] = 8'd3;
    req_valid = 4'b0100;
    #1;
    expect_grant(2);
    step;
    step;
    for (int b = 0; b < 4; b++) begin
      beat(2, b == 3, 2'b00);
      check("busy_blk", 64'(req_ready), 64'd0);
      step;
      rvalid_m = 1'b0;
    end
    #1;
    check("regrant", 64'(req_ready), 64'd4);
    expect_grant(2);
    step;
    req_valid = '0;
    step;
    beat(2, 1'b1, 2'b00);
    step;
    rvalid_m = 1'b0;
    // bad rid
    check("err_clean", 64'(err), 64'd0);
    beat(5, 1'b1, 2'b00);
    step;
    rvalid_m = 1'b0;
    check("err_badrid", 64'(err), 64'd1);
    // async reset while in ISSUE
    req_valid = 4'b0001;
    #1;
    expect_grant(0);
    step;
    req_valid = '0;
    step;
    arready_m = 1'b0;
    req_valid = 4'b1000;
    #1;
    expect_grant(3);
    step;
    req_valid = '0;
    check("ar_issue", 64'(arvalid_m), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    ar_q.delete();
    check("ar_rst_arvalid", 64'(arvalid_m), 64'd0);
    check("ar_rst_err", 64'(err), 64'd0);
    check("ar_rst_araddr", araddr_m, 64'd0);
    step;
    rst = 1'b1;
    arready_m = 1'b1;
    req_valid = 4'b0001;
    #1;
    check("ar_rst_busy", 64'(req_ready), 64'd1);
    expect_grant(0);
    step;
    req_valid = '0;
    step;
    beat(2, 1'b1, 2'b00);
    step;
    rvalid_m = 1'b0;
    check("err_unexpected", 64'(err), 64'd1);
    // error response still delivered
    do_reset;
    req_valid = 4'b0010;
    #1;
    expect_grant(1);
    step;
    req_valid = '0;
    step;
    beat(1, 1'b1, 2'b10);
    step;
    rvalid_m = 1'b0;
    check("err_rresp", 64'(err), 64'd1);
    check("ar_q_empty", 64'(ar_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
